// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with ready/ack handshake and framing-error flag.
// Define RX_PARITY_EN to expect an even-parity bit between the data and the stop bit.
module uart_rx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_si,
   input  logic                 rx_data_ack,
   output logic [DATA_BITS-1:0] rx_po,
   output logic                 rx_busy,
   output logic                 rx_ready,
   output logic                 rx_error
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA,
`ifdef RX_PARITY_EN
      PARITY,
`endif
      STOP, WAIT_HIGH
   } state_t;

   state_t               state_q, state_d;
   logic                 s1_q, rs_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d, po_q, po_d;
   logic                 rdy_q, rdy_d, err_q, err_d, perr_q, perr_d;
   logic                 tick;

   assign tick     = cnt_q == FULL;
   assign rx_po    = po_q;
   assign rx_ready = rdy_q;
   assign rx_error = err_q;
   assign rx_busy  = !(state_q == IDLE || state_q == WAIT_HIGH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b1;
         rs_q    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         po_q    <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         s1_q    <= rx_si;
         rs_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         po_q    <= po_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         perr_q  <= perr_d;
      end
   end

   // Ack clears the flags by default; a completing frame overrides that below.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      po_d    = po_q;
      perr_d  = perr_q;
      rdy_d   = rdy_q & ~rx_data_ack;
      err_d   = err_q & ~rx_data_ack;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            perr_d = 1'b0;
            if (!rs_q) state_d = START;
         end
         START: if (cnt_q == HALF) begin
            cnt_d   = '0;
            state_d = rs_q ? IDLE : DATA;
         end
         DATA: if (tick) begin
            cnt_d = '0;
            sh_d  = {rs_q, sh_q[DATA_BITS-1:1]};
            bit_d = bit_q + 1'b1;
`ifdef RX_PARITY_EN
            if (bit_q == LAST) state_d = PARITY;
`else
            if (bit_q == LAST) state_d = STOP;
`endif
         end
`ifdef RX_PARITY_EN
         PARITY: if (tick) begin
            cnt_d   = '0;
            perr_d  = rs_q ^ (^sh_q);
            state_d = STOP;
         end
`endif
         STOP: if (tick) begin
            cnt_d   = '0;
            po_d    = sh_q;
            rdy_d   = rs_q & ~perr_q;
            err_d   = ~rs_q | perr_q;
            state_d = rs_q ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: if (rs_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx at CLKS_PER_BIT=8 (80 ns bits, 10 ns clock).
module tb_uart_rx;
   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_si = 1'b1;
   logic       rx_data_ack = 1'b0;
   logic [7:0] rx_po;
   logic       rx_busy, rx_ready, rx_error;

   int n_cmp = 0;
   int n_bad = 0;
   logic busy_all, rdy_all, po_keep;
   logic [7:0] po_ref;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx_si(rx_si), .rx_data_ack(rx_data_ack),
      .rx_po(rx_po), .rx_busy(rx_busy), .rx_ready(rx_ready), .rx_error(rx_error)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame; records whether busy/ready held and rx_po stayed at po_ref during the data bits.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      busy_all = 1'b1;
      rdy_all  = 1'b1;
      po_keep  = 1'b1;
      cyc(1);
      rx_si = 1'b0;
      cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_si = d[i];
         cyc(CPB);
         busy_all = busy_all & rx_busy;
         rdy_all  = rdy_all & rx_ready;
         po_keep  = po_keep & (rx_po == po_ref);
      end
      rx_si = stop;
      cyc(CPB);
   endtask

   task automatic pulse_ack(input int n);
      rx_data_ack = 1'b1;
      cyc(n);
      rx_data_ack = 1'b0;
      cyc(1);
   endtask

   task automatic test_reset;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
      rx_si = 1'b0;
      cyc(20);
      n_cmp++;
      if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL reset_prebusy: busy=%b want 1", rx_busy); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rx_po, rx_busy, rx_ready, rx_error} !== 11'h0) begin
         n_bad++;
         $display("FAIL reset_async: po=%h busy=%b rdy=%b err=%b want all 0", rx_po, rx_busy, rx_ready, rx_error);
      end
      rx_si = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(20);
      n_cmp++;
      if ({rx_po, rx_busy, rx_ready, rx_error} !== 11'h0) begin
         n_bad++;
         $display("FAIL reset_idle: po=%h busy=%b rdy=%b err=%b want all 0", rx_po, rx_busy, rx_ready, rx_error);
      end
   endtask

   task automatic test_valid;
      int lat;
      po_ref = 8'h00;
      lat = 0;
      fork
         send_frame(8'h55, 1'b1);
         begin
            cyc(1);
            while (!rx_ready && lat < 200) begin
               cyc(1);
               lat++;
            end
         end
      join
      n_cmp++;
      if (lat < 76 || lat > 80) begin n_bad++; $display("FAIL valid_latency: %0d clk want 76..80", lat); end
      n_cmp++;
      if (busy_all !== 1'b1) begin n_bad++; $display("FAIL valid_busy_during: %b want 1", busy_all); end
      n_cmp++;
      if (po_keep !== 1'b1) begin n_bad++; $display("FAIL valid_po_stable: %b want 1", po_keep); end
      n_cmp++;
      if ({rx_po, rx_ready, rx_error, rx_busy} !== {8'h55, 3'b100}) begin
         n_bad++;
         $display("FAIL valid_result: po=%h rdy=%b err=%b busy=%b want 55 1 0 0", rx_po, rx_ready, rx_error, rx_busy);
      end
   endtask

   task automatic test_handshake;
      pulse_ack(2);
      n_cmp++;
      if ({rx_ready, rx_po} !== {1'b0, 8'h55}) begin
         n_bad++;
         $display("FAIL handshake: rdy=%b po=%h want 0 55", rx_ready, rx_po);
      end
   endtask

   task automatic test_framing;
      po_ref = 8'h55;
      send_frame(8'hD5, 1'b0);
      n_cmp++;
      if ({rx_po, rx_error, rx_ready, rx_busy} !== {8'hD5, 3'b100}) begin
         n_bad++;
         $display("FAIL framing_result: po=%h err=%b rdy=%b busy=%b want d5 1 0 0", rx_po, rx_error, rx_ready, rx_busy);
      end
      cyc(4 * CPB);
      n_cmp++;
      if ({rx_busy, rx_error} !== 2'b01) begin
         n_bad++;
         $display("FAIL framing_held_low: busy=%b err=%b want 0 1", rx_busy, rx_error);
      end
      rx_si = 1'b1;
      cyc(6);
      n_cmp++;
      if ({rx_busy, rx_error, rx_ready} !== 3'b010) begin
         n_bad++;
         $display("FAIL framing_line_high: busy=%b err=%b rdy=%b want 0 1 0", rx_busy, rx_error, rx_ready);
      end
      pulse_ack(1);
      n_cmp++;
      if ({rx_error, rx_po} !== {1'b0, 8'hD5}) begin
         n_bad++;
         $display("FAIL framing_ack: err=%b po=%h want 0 d5", rx_error, rx_po);
      end
   endtask

   task automatic test_false_start;
      int nb;
      logic flag;
      nb = 0;
      flag = 1'b0;
      rx_si = 1'b0;
      cyc(2);
      rx_si = 1'b1;
      for (int i = 0; i < 20; i++) begin
         nb += int'(rx_busy);
         flag |= rx_ready | rx_error;
         cyc(1);
      end
      n_cmp++;
      if (nb < 1 || nb > CPB / 2 + 2) begin n_bad++; $display("FAIL false_start_busy: %0d clk want 1..%0d", nb, CPB / 2 + 2); end
      n_cmp++;
      if ({flag, rx_po} !== {1'b0, 8'hD5}) begin
         n_bad++;
         $display("FAIL false_start_flags: flags=%b po=%h want 0 d5", flag, rx_po);
      end
   endtask

   task automatic test_back_to_back;
      po_ref = 8'hD5;
      send_frame(8'h55, 1'b1);
      n_cmp++;
      if ({rx_po, rx_ready} !== {8'h55, 1'b1}) begin
         n_bad++;
         $display("FAIL b2b_first: po=%h rdy=%b want 55 1", rx_po, rx_ready);
      end
      po_ref = 8'h55;
      send_frame(8'hA3, 1'b1);
      n_cmp++;
      if ({rdy_all, po_keep} !== 2'b11) begin
         n_bad++;
         $display("FAIL b2b_hold: rdy_held=%b po_held=%b want 1 1", rdy_all, po_keep);
      end
      n_cmp++;
      if ({rx_po, rx_ready, rx_error} !== {8'hA3, 2'b10}) begin
         n_bad++;
         $display("FAIL b2b_overrun: po=%h rdy=%b err=%b want a3 1 0", rx_po, rx_ready, rx_error);
      end
   endtask

   task automatic test_ack_collision;
      logic seen;
      seen = 1'b0;
      rx_data_ack = 1'b1;
      fork
         send_frame(8'h3C, 1'b1);
         for (int i = 0; i < 95; i++) begin
            cyc(1);
            if (rx_po == 8'h3C && rx_ready) seen = 1'b1;
         end
      join
      rx_data_ack = 1'b0;
      cyc(1);
      n_cmp++;
      if (seen !== 1'b1) begin n_bad++; $display("FAIL ack_collision_set: seen=%b want 1", seen); end
      n_cmp++;
      if ({rx_ready, rx_po} !== {1'b0, 8'h3C}) begin
         n_bad++;
         $display("FAIL ack_collision_clear: rdy=%b po=%h want 0 3c", rx_ready, rx_po);
      end
   endtask

   initial begin
      test_reset;
      test_valid;
      test_handshake;
      test_framing;
      test_false_start;
      test_back_to_back;
      pulse_ack(1);
      test_ack_collision;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
